dds_quad_nco: RTL

//  Parametrised quadrature NCO, successor to the single-output cosine DDS core.
//  - Phase accumulator with double-buffered frequency and phase-offset registers.
//  - Commit is either immediate or deferred to the accumulator wrap.
//  - Sin and cos are produced by a piecewise parabolic shaper.
//  - Sits under user_project_wrapper: config from la_data_in, samples to io_out/io_oeb.

---
 rtl/dds_pkg.sv | 20 ++
 rtl/dds_parabolic_shaper.sv | 49 ++++
 rtl/dds_quad_nco.sv | 130 +++++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// Shared defaults and elaboration helpers for the quadrature NCO.
// Imported by the NCO top and by its parabolic shaper.
package dds_pkg;

  localparam int unsigned ACC_W_DEF = 32;
  localparam int unsigned PH_W_DEF  = 12;
  localparam int unsigned OUT_W_DEF = 16;
  localparam int unsigned QUARTER   = 2 ** (PH_W_DEF - 2);

  // Right shift that scales the 2n-bit parabola product to OUT_W-1 magnitude bits.
  function automatic int unsigned shaper_shift(input int unsigned ph_w,
                                               input int unsigned out_w);
    return 2 * (ph_w - 1) - out_w - 1;
  endfunction

  function automatic bit width_ok(input int unsigned ph_w, input int unsigned out_w);
    return (2 * (ph_w - 1)) >= (out_w + 1);
  endfunction

endpackage

// File: rtl/dds_parabolic_shaper.sv
// Piecewise parabolic sine approximation: top phase bit is the sign, remaining
// bits form U, and the magnitude is U*(2^n-1-U). Two register stages.
module dds_parabolic_shaper
  import dds_pkg::*;
#(
  parameter int unsigned PH_W  = PH_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PH_W-1:0]         phase,
  output logic signed [OUT_W-1:0] sample
);

  localparam int unsigned N     = PH_W - 1;
  localparam int unsigned Shift = shaper_shift(PH_W, OUT_W);

  if (!width_ok(PH_W, OUT_W)) begin : g_width_check
    $error("dds_parabolic_shaper: PH_W is too narrow for OUT_W");
  end

  logic [N-1:0]     u;
  logic [N-1:0]     u_c;
  logic [2*N-1:0]   m_d;
  logic [2*N-1:0]   m_q;
  logic             sgn_q;
  logic [OUT_W-1:0] mag;

  always_comb begin
    u   = phase[N-1:0];
    // Bitwise inverse of U equals 2^n-1-U.
    u_c = ~u;
    m_d = {{N{1'b0}}, u} * {{N{1'b0}}, u_c};
    mag = OUT_W'(m_q >> Shift);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sgn_q  <= 1'b0;
      m_q    <= '0;
      sample <= '0;
    end else begin
      sgn_q  <= phase[PH_W-1];
      m_q    <= m_d;
      sample <= sgn_q ? -mag : mag;
    end
  end

endmodule

// File: rtl/dds_quad_nco.sv
// Quadrature NCO: double-buffered frequency/phase-offset, phase accumulator,
// phase truncation stage and two parabolic shapers producing sin and cos.
module dds_quad_nco
  import dds_pkg::*;
#(
  parameter int unsigned ACC_W          = ACC_W_DEF,
  parameter int unsigned PH_W           = PH_W_DEF,
  parameter int unsigned OUT_W          = OUT_W_DEF,
  parameter int unsigned COMMIT_ON_WRAP = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    Enable,
  input  logic                    LoadF,
  input  logic                    LoadP,
  input  logic                    Commit,
  input  logic                    Sync_Clr,
  input  logic [ACC_W-1:0]        FreqPhase,
  output logic signed [OUT_W-1:0] Sin_Out,
  output logic signed [OUT_W-1:0] Cos_Out,
  output logic                    Out_Valid,
  output logic                    Wrap,
  output logic [OUT_W-1:0]        io_oeb
);

  localparam logic [PH_W-1:0] Quarter = PH_W'(1) << (PH_W - 2);

  logic [ACC_W-1:0] fsh_q, fsh_d;
  logic [ACC_W-1:0] psh_q, psh_d;
  logic [ACC_W-1:0] freq_q, freq_d;
  logic [ACC_W-1:0] poff_q, poff_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             pend_q, pend_d;
  logic             wrap_q, wrap_d;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic             apply;
  logic [ACC_W-1:0] phase_sum;
  logic [PH_W-1:0]  p;
  logic [PH_W-1:0]  ps_q;
  logic [PH_W-1:0]  pc_q;
  logic [2:0]       valid_q;
  logic             oe_q;

  always_comb begin
    fsh_d = LoadF ? FreqPhase : fsh_q;
    psh_d = LoadP ? FreqPhase : psh_q;
    sum   = {1'b0, acc_q} + {1'b0, freq_q};
    carry = sum[ACC_W];

    // Deferred mode lands a commit on the carry edge, or early on Sync_Clr.
    if (COMMIT_ON_WRAP == 0) begin
      apply  = Commit;
      pend_d = 1'b0;
    end else begin
      apply  = (pend_q | Commit) & (Sync_Clr | (Enable & carry));
      pend_d = (pend_q | Commit) & ~apply;
    end

    freq_d = apply ? fsh_d : freq_q;
    poff_d = apply ? psh_d : poff_q;

    if (Sync_Clr) begin
      acc_d  = '0;
      wrap_d = 1'b0;
    end else if (Enable) begin
      acc_d  = sum[ACC_W-1:0];
      wrap_d = carry;
    end else begin
      acc_d  = acc_q;
      wrap_d = 1'b0;
    end

    phase_sum = acc_q + poff_q;
    p         = PH_W'(phase_sum >> (ACC_W - PH_W));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsh_q   <= '0;
      psh_q   <= '0;
      freq_q  <= '0;
      poff_q  <= '0;
      acc_q   <= '0;
      pend_q  <= 1'b0;
      wrap_q  <= 1'b0;
      ps_q    <= '0;
      pc_q    <= '0;
      valid_q <= '0;
      oe_q    <= 1'b0;
    end else begin
      fsh_q   <= fsh_d;
      psh_q   <= psh_d;
      freq_q  <= freq_d;
      poff_q  <= poff_d;
      acc_q   <= acc_d;
      pend_q  <= pend_d;
      wrap_q  <= wrap_d;
      ps_q    <= p;
      pc_q    <= p + Quarter;
      valid_q <= {valid_q[1:0], Enable};
      if (Enable) oe_q <= 1'b1;
    end
  end

  dds_parabolic_shaper #(
    .PH_W  (PH_W),
    .OUT_W (OUT_W)
  ) u_sin (
    .clk    (clk),
    .rst    (rst),
    .phase  (ps_q),
    .sample (Sin_Out)
  );

  dds_parabolic_shaper #(
    .PH_W  (PH_W),
    .OUT_W (OUT_W)
  ) u_cos (
    .clk    (clk),
    .rst    (rst),
    .phase  (pc_q),
    .sample (Cos_Out)
  );

  assign Out_Valid = valid_q[2];
  assign Wrap      = wrap_q;
  assign io_oeb    = {OUT_W{~oe_q}};

endmodule
